// File: rtl/hsi_frame_coder.sv
// HSI serial frame coder: buffers parallel words in a small FIFO and emits
// start/data/parity/stop frames on q, one bit per clk_en pulse.
module hsi_frame_coder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned MSB_FIRST   = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] d,
  input  logic              d_rdy,
  input  logic              ovf_clr,
  output logic              full,
  output logic              busy,
  output logic              ovf,
  output logic              q
);

  localparam int unsigned PAR_W     = (PARITY_MODE != 0) ? 1 : 0;
  localparam int unsigned FRAME_LEN = 1 + DATA_W + PAR_W + STOP_BITS;
  localparam int unsigned SH_W      = FRAME_LEN - 1;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned BW        = $clog2(FRAME_LEN);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [0:0]        r_state;
  logic [BW-1:0]     r_bit_cnt;
  logic [SH_W-1:0]   r_sh;
  logic              r_q, r_full, r_busy, r_ovf;

  logic [AW-1:0]        w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic [0:0]           w_state_nxt;
  logic [BW-1:0]        w_bit_cnt_nxt;
  logic [SH_W-1:0]      w_sh_nxt;
  logic                 w_q_nxt, w_full_nxt, w_busy_nxt, w_ovf_nxt;
  logic                 w_full_pre, w_nonempty, w_last;
  logic                 w_push, w_drop, w_pop;
  logic [DATA_W-1:0]    w_rd_data;
  logic [FRAME_LEN-1:0] w_frame;

  assign w_full_pre = (r_count == CW'(FIFO_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_last     = (r_state == S_SEND) && (r_bit_cnt == BW'(FRAME_LEN - 1));
  assign w_push     = clk_en & d_rdy & ~w_full_pre;
  assign w_drop     = clk_en & d_rdy & w_full_pre;
  assign w_pop      = clk_en & w_nonempty & ((r_state == S_IDLE) | w_last);
  assign w_rd_data  = r_mem[r_rd_ptr];

  // Full frame image of the head word, bit 0 goes out first.
  always_comb begin
    w_frame    = '1;
    w_frame[0] = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (MSB_FIRST != 0) w_frame[1 + i] = w_rd_data[DATA_W - 1 - i];
      else                w_frame[1 + i] = w_rd_data[i];
    end
    if (PARITY_MODE == 1)      w_frame[1 + DATA_W] = ~^w_rd_data;
    else if (PARITY_MODE == 2) w_frame[1 + DATA_W] = ^w_rd_data;
  end

  // Next-state and datapath; with clk_en low everything holds.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sh_nxt      = r_sh;
    w_q_nxt       = r_q;
    w_wr_ptr_nxt  = r_wr_ptr + AW'(w_push);
    w_rd_ptr_nxt  = r_rd_ptr + AW'(w_pop);
    w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    w_ovf_nxt     = w_drop | (r_ovf & ~(clk_en & ovf_clr));

    if (w_pop) begin
      w_state_nxt   = S_SEND;
      w_bit_cnt_nxt = '0;
      w_q_nxt       = w_frame[0];
      w_sh_nxt      = w_frame[FRAME_LEN-1:1];
    end else if (clk_en && (r_state == S_SEND)) begin
      if (w_last) begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
        w_q_nxt       = 1'b1;
      end else begin
        w_q_nxt       = r_sh[0];
        w_sh_nxt      = {1'b1, r_sh[SH_W-1:1]};
        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
      end
    end

    w_full_nxt = (w_count_nxt == CW'(FIFO_DEPTH));
    w_busy_nxt = (w_state_nxt == S_SEND) | (w_count_nxt != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_sh      <= '1;
      r_q       <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sh      <= w_sh_nxt;
      r_q       <= w_q_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_full    <= w_full_nxt;
      r_busy    <= w_busy_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // Storage needs no reset: only slots covered by the count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= d;
  end

  assign q    = r_q;
  assign full = r_full;
  assign busy = r_busy;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_hsi_frame_coder.sv
// Directed bench for hsi_frame_coder: three parameterisations, hand-derived bit streams.
module tb_hsi_frame_coder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en0, rdy0, clr0, full0, busy0, ovf0, q0;
  logic [7:0] d0;
  logic       en1, rdy1, clr1, full1, busy1, ovf1, q1;
  logic [7:0] d1;
  logic       en2, rdy2, clr2, full2, busy2, ovf2, q2;
  logic [4:0] d2;

  hsi_frame_coder u_def (
    .clk(clk), .n_rst(rst_n), .clk_en(en0), .d(d0), .d_rdy(rdy0), .ovf_clr(clr0),
    .full(full0), .busy(busy0), .ovf(ovf0), .q(q0));

  hsi_frame_coder #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(1)) u_msb (
    .clk(clk), .n_rst(rst_n), .clk_en(en1), .d(d1), .d_rdy(rdy1), .ovf_clr(clr1),
    .full(full1), .busy(busy1), .ovf(ovf1), .q(q1));

  hsi_frame_coder #(.DATA_W(5), .PARITY_MODE(0)) u_w5 (
    .clk(clk), .n_rst(rst_n), .clk_en(en2), .d(d2), .d_rdy(rdy2), .ovf_clr(clr2),
    .full(full2), .busy(busy2), .ovf(ovf2), .q(q2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Default-config frame bit i of word w: start, LSB-first data, odd parity, stop.
  function automatic logic bit_def(input logic [7:0] w, input int i);
    if (i == 0)      return 1'b0;
    else if (i <= 8) return w[i-1];
    else if (i == 9) return ~^w;
    else             return 1'b1;
  endfunction

  logic [0:11] e1 = 12'b010100101111;
  logic [0:12] e2 = 13'b0101001010111;
  logic [0:7]  e6 = 8'b01111111;
  logic [0:11] e5 = 12'b011110000111;
  logic        q_log [0:63];
  logic        b_log [0:63];

  initial begin
    rst_n = 1'b0;
    en0 = 1'b1; rdy0 = 1'b0; clr0 = 1'b0; d0 = '0;
    en1 = 1'b1; rdy1 = 1'b0; clr1 = 1'b0; d1 = '0;
    en2 = 1'b1; rdy2 = 1'b0; clr2 = 1'b0; d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_full", full0, 1'b0);
    chk("rst_ovf", ovf0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: defaults, 0xA5
    d0 = 8'hA5; rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    chk("t1_busy_push", busy0, 1'b1);
    chk("t1_q_push", q0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_q%0d", i), q0, e1[i]);
      chk($sformatf("t1_busy%0d", i), busy0, (i < 11) ? 1'b1 : 1'b0);
    end

    // 2: MSB first, even parity, two stop bits
    d1 = 8'hA5; rdy1 = 1'b1;
    @(posedge clk); #1;
    rdy1 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_q%0d", i), q1, e2[i]);
      chk($sformatf("t2_busy%0d", i), busy1, (i < 12) ? 1'b1 : 1'b0);
    end

    // 6: 5-bit data, no parity
    d2 = 5'h1F; rdy2 = 1'b1;
    @(posedge clk); #1;
    rdy2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_q%0d", i), q2, e6[i]);
      chk($sformatf("t6_busy%0d", i), busy2, (i < 7) ? 1'b1 : 1'b0);
    end

    // 3: six pushes into a 4-deep FIFO, back-to-back frames, overflow
    for (int e = 1; e <= 60; e++) begin
      rdy0 = (e <= 6);
      d0   = 8'(e);
      @(posedge clk); #1;
      q_log[e] = q0;
      b_log[e] = busy0;
      if (e == 4)  chk("t3_full_e4", full0, 1'b0);
      if (e == 5)  chk("t3_full_e5", full0, 1'b1);
      if (e == 5)  chk("t3_ovf_e5", ovf0, 1'b0);
      if (e == 6)  chk("t3_ovf_e6", ovf0, 1'b1);
      if (e == 6)  chk("t3_full_e6", full0, 1'b1);
      if (e == 13) chk("t3_full_e13", full0, 1'b0);
    end
    rdy0 = 1'b0;
    for (int e = 2; e <= 56; e++)
      chk($sformatf("t3_q%0d", e), q_log[e], bit_def(8'((e - 2) / 11 + 1), (e - 2) % 11));
    for (int e = 57; e <= 60; e++)
      chk($sformatf("t3_idle%0d", e), q_log[e], 1'b1);
    chk("t3_busy56", b_log[56], 1'b1);
    chk("t3_busy57", b_log[57], 1'b0);
    chk("t3_ovf_sticky", ovf0, 1'b1);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("t3_ovf_clr", ovf0, 1'b0);

    // 4: clk_en every 4th clk; strobes between enables must be ignored
    for (int c = 0; c <= 51; c++) begin
      en0  = (c % 4 == 0);
      rdy0 = (c <= 3);
      d0   = (c == 0) ? 8'h3C : 8'hFF;
      @(posedge clk); #1;
      q_log[c] = q0;
      b_log[c] = busy0;
    end
    en0 = 1'b1; rdy0 = 1'b0;
    for (int c = 0; c <= 3; c++)
      chk($sformatf("t4_pre%0d", c), q_log[c], 1'b1);
    chk("t4_busy_hold", b_log[2], 1'b1);
    for (int c = 4; c <= 47; c++)
      chk($sformatf("t4_q%0d", c), q_log[c], bit_def(8'h3C, c / 4 - 1));
    for (int c = 48; c <= 51; c++)
      chk($sformatf("t4_idle%0d", c), q_log[c], 1'b1);
    chk("t4_busy47", b_log[47], 1'b1);
    chk("t4_busy48", b_log[48], 1'b0);

    // 5: async reset during data bit 3, with FIFO full and ovf set
    d0 = 8'h00; rdy0 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rdy0 = 1'b0;
    chk("t5_q_d3", q0, 1'b0);
    chk("t5_full_pre", full0, 1'b1);
    chk("t5_ovf_pre", ovf0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_q", q0, 1'b1);
    chk("t5_rst_busy", busy0, 1'b0);
    chk("t5_rst_full", full0, 1'b0);
    chk("t5_rst_ovf", ovf0, 1'b0);
    #1 rst_n = 1'b1;
    d0 = 8'h0F; rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_q%0d", i), q0, e5[i]);
    end
    chk("t5_busy_end", busy0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hsi_frame_coder.md
Name: hsi_frame_coder

Overview:
- Parametrised HSI serial frame coder. Successor to the fixed 8-bit, 11-bit-frame coder.
- Accepts parallel words into an internal FIFO and emits asynchronous-serial frames on q: start bit, data, optional parity, 1 or 2 stop bits.
- Bit order is configurable.
- Sits between the HSI master packet logic and the line driver. One bit period per clk_en pulse.

Parameters:
- DATA_W, 8, data bits per frame (5..16).
- PARITY_MODE, 1, 0 = no parity, 1 = odd (parity bit = ~^d), 2 = even (parity bit = ^d).
- STOP_BITS, 1, number of stop bits (1 or 2).
- MSB_FIRST, 0, 0 = data LSB first, 1 = data MSB first.
- FIFO_DEPTH, 4, input FIFO words (power of 2, >= 2).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- clk_en  in  1  bit-rate enable; all state advances only on clk edges with clk_en=1.
- d  in  DATA_W  data word to send.
- d_rdy  in  1  write strobe, sampled on clk_en edges.
- ovf_clr  in  1  clears ovf, sampled on clk_en edges.
- full  out  1  FIFO holds FIFO_DEPTH words.
- busy  out  1  frame in progress or FIFO non-empty.
- ovf  out  1  sticky: a write was dropped because FIFO was full.
- q  out  1  serial line output, registered, idle high.

Behaviour:
- Reset (async, n_rst=0):
  - q=1, full=0, busy=0, ovf=0.
  - FIFO emptied; state=IDLE; bit counter=0.
  - A frame in flight is abandoned immediately.
- clk_en=0: every register holds. Outputs stay stable.
- FRAME_LEN = 1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS.
- Parity is computed on the word as popped from the FIFO.
- Write rule:
  - On a clk_en edge, d_rdy=1 and full=0 pushes d.
  - d_rdy=1 with full=1 drops the word and sets ovf.
  - full uses the pre-edge count. A push while full is dropped even if a pop occurs on the same edge.
- ovf: set by a dropped write, cleared by ovf_clr. Set and clear on the same edge leaves ovf=1.
- FSM, two states:
  - IDLE: q=1. At a clk_en edge with FIFO non-empty (pre-edge count), pop one word, load the frame shift register, bit counter=0, go to SEND. q shows the start bit (0) from this edge.
  - SEND: each clk_en edge shifts the next frame bit onto q and increments the bit counter.
  - Frame end: at the edge ending the last stop bit (counter = FRAME_LEN-1):
    - FIFO non-empty: pop and load the next frame; q=start bit (back-to-back, no idle gap).
    - FIFO empty: go to IDLE, q=1.
- Bit order on q:
  - Start bit 0.
  - Data: d[0]..d[DATA_W-1] if MSB_FIRST=0, else d[DATA_W-1]..d[0].
  - Parity bit if enabled.
  - STOP_BITS ones.
- Latency: push at clk_en edge k (FIFO empty, IDLE) gives start bit on q after clk_en edge k+1.
- Simultaneous push and pop on one edge: count unchanged, both take effect.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is a log2(FIFO_DEPTH)+1-bit register.
- busy = (state==SEND) | (count!=0). It deasserts with the same edge that returns q to idle after the final frame.
- Each bit lasts exactly one clk_en period. With clk_en tied high, one bit = one clk.

Test Plan:
1. Single word, defaults, clk_en=1: push 0xA5.
   - One cycle later, q over 11 cycles = 0,1,0,1,0,0,1,0,1,1(parity),1(stop), then idle 1.
   - busy high for exactly 12 cycles from the push edge.
2. MSB_FIRST=1, PARITY_MODE=2, STOP_BITS=2: push 0xA5.
   - q = 0,1,0,1,0,0,1,0,1,0(parity),1,1. Frame is 12 bits, then idle.
3. Back-to-back and overflow, FIFO_DEPTH=4: push 6 words 0x01..0x06 on consecutive edges.
   - full asserts after the 5th push; the 6th push is dropped and ovf=1.
   - Frames 0x01..0x05 are sent with no idle gap between stop and start bits.
   - Assert ovf_clr: ovf returns to 0.
4. clk_en every 4th clk: push 0x3C.
   - Each q bit is held exactly 4 clk cycles.
   - No register changes on clk_en=0 cycles.
5. Reset mid-frame: assert n_rst low during data bit 3.
   - q=1, busy=0, full=0, ovf=0 immediately, without waiting for a clock.
   - After release, push 0x0F: a complete correct frame is sent.
6. PARITY_MODE=0, DATA_W=5: push 0x1F.
   - q = 0,1,1,1,1,1,1 (7 bits, no parity bit).
